// File: rtl/shifter_pipe.sv
// Pipelined log2 barrel shifter with valid/ready handshakes and a tag sideband.
// Right shifts reuse the left-shift core by bit-reversing the operand at entry and exit.
module shifter_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAGW-1:0]         out_tag,
  output logic                    out_err
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = '0;
    for (int j = 0; j < XLEN; j++) r[j] = d[XLEN-1-j];
    return r;
  endfunction

  function automatic logic is_right(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic is_rot(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // One mux level: shift left by 2^k; rotates refill with the bits pushed out the top.
  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] d, input int k,
                                                  input logic [2:0] op, input logic sign);
    logic [XLEN-1:0] r;
    int amt;
    amt = 1 << k;
    r = d << amt;
    for (int j = 0; j < XLEN; j++) begin
      if (j < amt) begin
        if (is_rot(op)) r[j] = d[XLEN-amt+j];
        else if (op == OP_SRA) r[j] = sign;
        else r[j] = 1'b0;
      end
    end
    return r;
  endfunction

  // First level owned by stage i; the earliest stages absorb any remainder.
  function automatic int lvl_lo(input int i);
    return i * (SHW / STAGES) + ((i < (SHW % STAGES)) ? i : (SHW % STAGES));
  endfunction

  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] err_r;
  logic              sign_r  [STAGES];
  logic [XLEN-1:0]   data_r  [STAGES];
  logic [SHW-1:0]    shamt_r [STAGES];
  logic [2:0]        op_r    [STAGES];
  logic [TAGW-1:0]   tag_r   [STAGES];

  logic [STAGES:0]   rdy_s;
  logic [STAGES-1:0] src_valid_s;
  logic [STAGES-1:0] src_err_s;
  logic              src_sign_s  [STAGES];
  logic [XLEN-1:0]   src_data_s  [STAGES];
  logic [SHW-1:0]    src_shamt_s [STAGES];
  logic [2:0]        src_op_s    [STAGES];
  logic [TAGW-1:0]   src_tag_s   [STAGES];
  logic [XLEN-1:0]   nxt_data_s  [STAGES];
  logic [XLEN-1:0]   acc_s;
  int                prv_s;

  // Backward ready chain: a stage can load when empty or when it drains this cycle.
  always_comb begin
    rdy_s = '0;
    rdy_s[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) rdy_s[i] = ~valid_r[i] | rdy_s[i+1];
  end

  // Per-stage source selection and the mux levels each stage owns.
  always_comb begin
    src_valid_s = '0;
    src_err_s   = '0;
    acc_s       = '0;
    prv_s       = 0;
    for (int i = 0; i < STAGES; i++) begin
      src_sign_s[i]  = 1'b0;
      src_data_s[i]  = '0;
      src_shamt_s[i] = '0;
      src_op_s[i]    = '0;
      src_tag_s[i]   = '0;
      nxt_data_s[i]  = '0;
    end
    for (int i = 0; i < STAGES; i++) begin
      prv_s = (i > 0) ? i - 1 : 0;
      if (i == 0) begin
        src_valid_s[i] = in_valid;
        src_err_s[i]   = (in_op > OP_ROR);
        src_sign_s[i]  = in_data[XLEN-1];
        src_data_s[i]  = is_right(in_op) ? bit_rev(in_data) : in_data;
        src_shamt_s[i] = in_shamt;
        src_op_s[i]    = in_op;
        src_tag_s[i]   = in_tag;
      end else begin
        src_valid_s[i] = valid_r[prv_s];
        src_err_s[i]   = err_r[prv_s];
        src_sign_s[i]  = sign_r[prv_s];
        src_data_s[i]  = data_r[prv_s];
        src_shamt_s[i] = shamt_r[prv_s];
        src_op_s[i]    = op_r[prv_s];
        src_tag_s[i]   = tag_r[prv_s];
      end
      acc_s = src_data_s[i];
      for (int k = 0; k < SHW; k++) begin
        if (k >= lvl_lo(i) && k < lvl_lo(i + 1) && src_shamt_s[i][k]) begin
          acc_s = shift_level(acc_s, k, src_op_s[i], src_sign_s[i]);
        end else begin
          acc_s = acc_s;
        end
      end
      // The last stage also undoes the entry reversal and squashes illegal ops.
      if (i == STAGES - 1) begin
        if (src_err_s[i]) acc_s = '0;
        else if (is_right(src_op_s[i])) acc_s = bit_rev(acc_s);
        else acc_s = acc_s;
      end else begin
        acc_s = acc_s;
      end
      nxt_data_s[i] = acc_s;
    end
  end

  // Stage registers; payload only updates when a valid operation moves in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      err_r   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        sign_r[i]  <= 1'b0;
        data_r[i]  <= '0;
        shamt_r[i] <= '0;
        op_r[i]    <= '0;
        tag_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy_s[i]) begin
          valid_r[i] <= src_valid_s[i];
          if (src_valid_s[i]) begin
            err_r[i]   <= src_err_s[i];
            sign_r[i]  <= src_sign_s[i];
            data_r[i]  <= nxt_data_s[i];
            shamt_r[i] <= src_shamt_s[i];
            op_r[i]    <= src_op_s[i];
            tag_r[i]   <= src_tag_s[i];
          end
        end
      end
    end
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = valid_r[STAGES-1];
  assign out_data  = data_r[STAGES-1];
  assign out_tag   = tag_r[STAGES-1];
  assign out_err   = err_r[STAGES-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: directed vectors plus a reference-model sweep.
module tb_shifter_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAGW   = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = 3'd0;
  logic [XLEN-1:0] in_data = '0;
  logic [4:0]      in_shamt = 5'd0;
  logic [TAGW-1:0] in_tag = '0;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_err;

  logic rnd_rdy = 1'b0;
  logic rnd_bit = 1'b1;
  logic rdy_hold = 1'b1;
  assign out_ready = rnd_rdy ? rnd_bit : rdy_hold;

  shifter_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [XLEN-1:0] d;
    logic [TAGW-1:0] tag;
    logic            err;
    int              lat_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      3'd0: return d << s;
      3'd1: return d >> s;
      3'd2: return sd >>> s;
      3'd3: return (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
      3'd4: return (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: every output transfer pops and compares the oldest expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {59'd0, out_tag}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_tag", out_tag, e.tag);
        check("out_err", out_err, e.err);
        if (e.lat_cyc >= 0) check("latency", cyc, e.lat_cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                       input logic [4:0] tag, input logic [31:0] exp_d, input logic exp_err,
                       input bit chk_lat);
    exp_t e;
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("issue_timeout", in_ready, 1);
    end else begin
      e.d = exp_d;
      e.tag = tag;
      e.err = exp_err;
      e.lat_cyc = chk_lat ? cyc + STAGES : -1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_err", out_err, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    issue(3'd0, 32'h0000_0001, 5'd31, 5'd7, 32'h8000_0000, 1'b0, 1'b1);
    drain();

    issue(3'd2, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000, 1'b0, 1'b1);
    issue(3'd1, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000, 1'b0, 1'b1);
    issue(3'd0, 32'h1234_5678, 5'd0, 5'd3, 32'h1234_5678, 1'b0, 1'b1);
    drain();

    issue(3'd4, 32'h0000_00FF, 5'd4, 5'd4, 32'hF000_000F, 1'b0, 1'b1);
    issue(3'd3, 32'h8000_0001, 5'd1, 5'd5, 32'h0000_0003, 1'b0, 1'b1);
    issue(3'd4, 32'hDEAD_BEEF, 5'd0, 5'd6, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(3'd3, 32'h0000_0001, 5'd31, 5'd8, 32'h8000_0000, 1'b0, 1'b1);
    issue(3'd2, 32'h8000_0000, 5'd31, 5'd10, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(3'd2, 32'h7FFF_FFFF, 5'd31, 5'd11, 32'h0000_0000, 1'b0, 1'b1);
    drain();

    // Backpressure: two ops fill the pipe, the third must wait.
    rdy_hold = 1'b0;
    issue(3'd0, 32'h0000_00A5, 5'd4, 5'd1, 32'h0000_0A50, 1'b0, 1'b0);
    issue(3'd3, 32'h1234_5678, 5'd8, 5'd2, 32'h3456_7812, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_op = 3'd1;
    in_data = 32'hF000_0000;
    in_shamt = 5'd28;
    in_tag = 5'd3;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_tag", out_tag, 1);
      check("stall_out_data", out_data, 32'h0000_0A50);
    end
    @(posedge clk);
    #1;
    rdy_hold = 1'b1;
    issue(3'd1, 32'hF000_0000, 5'd28, 5'd3, 32'h0000_000F, 1'b0, 1'b0);
    drain();

    issue(3'b110, 32'hFFFF_FFFF, 5'd5, 5'd9, 32'h0000_0000, 1'b1, 1'b1);
    issue(3'd0, 32'h0000_0003, 5'd2, 5'd12, 32'h0000_000C, 1'b0, 1'b1);
    drain();

    // Reset with two operations in flight.
    rdy_hold = 1'b0;
    issue(3'd0, 32'h0000_0001, 5'd1, 5'd13, 32'h0000_0002, 1'b0, 1'b0);
    issue(3'd0, 32'h0000_0001, 5'd2, 5'd14, 32'h0000_0004, 1'b0, 1'b0);
    check("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_hold = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    repeat (5) begin
      @(negedge clk);
      check("no_stale_output", out_valid, 0);
    end
    @(posedge clk);
    #1;

    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = $urandom;
      s  = 5'($urandom_range(0, 31));
      issue(op, d, s, 5'(i), ref_shift(op, d, s), (op > 3'd4), 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rnd_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
